// File: rtl/speck_block_cipher_param_if.sv
// Host-side bundle for the SPECK engine: key load, start/done handshake and data.
interface speck_block_cipher_param_if #(
    parameter int WORD      = 32,
    parameter int KEY_WORDS = 4
);
    logic                      key_load;
    logic [WORD*KEY_WORDS-1:0] key;
    logic                      key_ready;
    logic                      start;
    logic                      mode;
    logic [2*WORD-1:0]         din;
    logic                      busy;
    logic                      done;
    logic [2*WORD-1:0]         dout;

    modport master (
        output key_load, key, start, mode, din,
        input  key_ready, busy, done, dout
    );

    modport slave (
        input  key_load, key, start, mode, din,
        output key_ready, busy, done, dout
    );
endinterface

// File: rtl/speck_block_cipher_param.sv
// Iterative SPECK encrypt/decrypt core with on-chip key expansion.
// One round (or one key-schedule step) per clock.
module speck_block_cipher_param #(
    parameter int WORD      = 32,
    parameter int KEY_WORDS = 4,
    parameter int ROUNDS    = 27,
    parameter int ALPHA     = 8,
    parameter int BETA      = 3
) (
    input logic                     clk,
    input logic                     reset,
    speck_block_cipher_param_if.slave bus
);
    localparam int CW = (ROUNDS > 2) ? $clog2(ROUNDS) : 1;
    localparam int LW = KEY_WORDS - 1;
    localparam logic [CW-1:0] LAST_ENC = CW'(ROUNDS - 1);
    localparam logic [CW-1:0] LAST_EXP = CW'(ROUNDS - 2);

    typedef enum logic [1:0] {IDLE, EXPAND, RUN, FINISH} state_t;

    state_t r_state;
    state_t w_next;

    logic [WORD-1:0]   r_x;
    logic [WORD-1:0]   r_y;
    logic [WORD-1:0]   r_rkc;
    logic [2*WORD-1:0] r_dout;
    logic [WORD-1:0]   r_l [LW];
    logic [WORD-1:0]   r_rk [ROUNDS];
    logic [CW-1:0]     r_cnt;
    logic              r_mode;
    logic              r_key_ready;
    logic              r_done;

    logic            w_accept;
    logic            w_key_acc;
    logic            w_start_acc;
    logic            w_exp_last;
    logic            w_run_last;
    logic            w_busy;
    logic [CW-1:0]   w_term;
    logic [CW-1:0]   w_cnt_inc;
    logic [WORD-1:0] w_k;
    logic [WORD-1:0] w_l_new;
    logic [WORD-1:0] w_rk_new;
    logic [WORD-1:0] w_ex;
    logic [WORD-1:0] w_ey;
    logic [WORD-1:0] w_dx;
    logic [WORD-1:0] w_dy;

    function automatic logic [WORD-1:0] ror(input logic [WORD-1:0] v, input int s);
        return (v >> s) | (v << (WORD - s));
    endfunction

    function automatic logic [WORD-1:0] rol(input logic [WORD-1:0] v, input int s);
        return (v << s) | (v >> (WORD - s));
    endfunction

    // FINISH behaves like IDLE for new requests so back-to-back blocks chain.
    assign w_accept    = (r_state == IDLE) || (r_state == FINISH);
    assign w_key_acc   = w_accept && bus.key_load;
    assign w_start_acc = w_accept && bus.start && r_key_ready && !bus.key_load;

    // Shared terminal compare for both round directions.
    assign w_term     = r_mode ? '0 : LAST_ENC;
    assign w_run_last = (r_cnt == w_term);
    assign w_exp_last = (r_cnt == LAST_EXP);
    assign w_cnt_inc  = r_cnt + CW'(1);

    assign w_k      = r_rk[r_cnt];
    assign w_l_new  = (r_rkc + ror(r_l[0], ALPHA)) ^ WORD'(r_cnt);
    assign w_rk_new = rol(r_rkc, BETA) ^ w_l_new;
    assign w_ex     = (ror(r_x, ALPHA) + r_y) ^ w_k;
    assign w_ey     = rol(r_y, BETA) ^ w_ex;
    assign w_dy     = ror(r_x ^ r_y, BETA);
    assign w_dx     = rol((r_x ^ w_k) - w_dy, ALPHA);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE, FINISH: begin
                if (w_key_acc) begin
                    w_next = EXPAND;
                end else if (w_start_acc) begin
                    w_next = RUN;
                end else begin
                    w_next = IDLE;
                end
            end
            EXPAND: if (w_exp_last) w_next = IDLE;
            RUN:    if (w_run_last) w_next = FINISH;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state == EXPAND) || (r_state == RUN);
    end

    assign bus.busy      = w_busy;
    assign bus.key_ready = r_key_ready;
    assign bus.done      = r_done;
    assign bus.dout      = r_dout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x         <= '0;
            r_y         <= '0;
            r_rkc       <= '0;
            r_dout      <= '0;
            r_cnt       <= '0;
            r_mode      <= 1'b0;
            r_key_ready <= 1'b0;
            r_done      <= 1'b0;
            for (int j = 0; j < LW; j++) r_l[j] <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_state == FINISH) begin
                r_dout <= {r_x, r_y};
                r_done <= 1'b1;
            end
            if (w_key_acc) begin
                r_key_ready <= 1'b0;
                r_rkc       <= bus.key[WORD-1:0];
                r_cnt       <= '0;
                for (int j = 0; j < LW; j++) begin
                    r_l[j] <= bus.key[WORD*(j+1) +: WORD];
                end
            end else if (w_start_acc) begin
                r_x    <= bus.din[2*WORD-1:WORD];
                r_y    <= bus.din[WORD-1:0];
                r_mode <= bus.mode;
                r_cnt  <= bus.mode ? LAST_ENC : '0;
            end
            if (r_state == EXPAND) begin
                r_rkc <= w_rk_new;
                for (int j = 0; j < LW - 1; j++) r_l[j] <= r_l[j+1];
                r_l[LW-1] <= w_l_new;
                if (w_exp_last) begin
                    r_cnt       <= '0;
                    r_key_ready <= 1'b1;
                end else begin
                    r_cnt <= w_cnt_inc;
                end
            end
            if (r_state == RUN) begin
                r_x <= r_mode ? w_dx : w_ex;
                r_y <= r_mode ? w_dy : w_ey;
                if (!w_run_last) begin
                    r_cnt <= r_mode ? (r_cnt - CW'(1)) : w_cnt_inc;
                end
            end
        end
    end

    // Key file carries no reset; key_ready guards its validity.
    always_ff @(posedge clk) begin
        if (w_key_acc) begin
            r_rk[0] <= bus.key[WORD-1:0];
        end else if (r_state == EXPAND) begin
            r_rk[w_cnt_inc] <= w_rk_new;
        end
    end
endmodule

// File: tb/tb_speck_block_cipher_param.sv
// Directed + randomized bench for speck_block_cipher_param at two widths,
// checked against an array-based SPECK reference model.
module tb_speck_block_cipher_param;
    localparam int WA = 32, MA = 4, TA = 27, AA = 8, BA = 3;
    localparam int WB = 16, MB = 4, TB = 22, AB = 7, BB = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    speck_block_cipher_param_if #(.WORD(WA), .KEY_WORDS(MA)) busA ();
    speck_block_cipher_param_if #(.WORD(WB), .KEY_WORDS(MB)) busB ();

    speck_block_cipher_param #(
        .WORD(WA), .KEY_WORDS(MA), .ROUNDS(TA), .ALPHA(AA), .BETA(BA)
    ) dutA (
        .clk(clk), .reset(reset), .bus(busA)
    );

    speck_block_cipher_param #(
        .WORD(WB), .KEY_WORDS(MB), .ROUNDS(TB), .ALPHA(AB), .BETA(BB)
    ) dutB (
        .clk(clk), .reset(reset), .bus(busB)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rotr(input logic [63:0] v, input int s, input int w);
        logic [63:0] m;
        m = (64'd1 << w) - 64'd1;
        return ((v >> s) | (v << (w - s))) & m;
    endfunction

    function automatic logic [63:0] rotl(input logic [63:0] v, input int s, input int w);
        logic [63:0] m;
        m = (64'd1 << w) - 64'd1;
        return ((v << s) | (v >> (w - s))) & m;
    endfunction

    function automatic logic [63:0] speck_ref(
        input logic [127:0] key, input int w, input int m, input int t,
        input int a, input int b, input logic dec, input logic [63:0] blk
    );
        logic [63:0] msk, x, y;
        logic [63:0] k [64];
        logic [63:0] l [96];
        msk  = (64'd1 << w) - 64'd1;
        k[0] = 64'(key) & msk;
        for (int j = 0; j < m - 1; j++) l[j] = 64'(key >> (w * (j + 1))) & msk;
        for (int i = 0; i < t - 1; i++) begin
            l[i+m-1] = ((k[i] + rotr(l[i], a, w)) & msk) ^ 64'(i);
            k[i+1]   = rotl(k[i], b, w) ^ l[i+m-1];
        end
        x = (blk >> w) & msk;
        y = blk & msk;
        if (!dec) begin
            for (int i = 0; i < t; i++) begin
                x = ((rotr(x, a, w) + y) & msk) ^ k[i];
                y = rotl(y, b, w) ^ x;
            end
        end else begin
            for (int i = t - 1; i >= 0; i--) begin
                y = rotr(x ^ y, b, w);
                x = rotl(((x ^ k[i]) - y) & msk, a, w);
            end
        end
        return (x << w) | y;
    endfunction

    function automatic logic [127:0] refkey_a(input logic [127:0] k);
        return k;
    endfunction

    task automatic a_keyload(input logic [127:0] k);
        int cyc;
        busA.key      = k;
        busA.key_load = 1'b1;
        @(negedge clk);
        busA.key_load = 1'b0;
        check("A_kr_drop", 64'(busA.key_ready), 64'd0);
        check("A_exp_busy", 64'(busA.busy), 64'd1);
        cyc = 0;
        while (!busA.key_ready && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("A_exp_lat", 64'(cyc), 64'(TA - 1));
        check("A_exp_idle", 64'(busA.busy), 64'd0);
    endtask

    task automatic a_op(input logic md, input logic [63:0] d, output logic [63:0] res, output int lat);
        busA.mode  = md;
        busA.din   = d;
        busA.start = 1'b1;
        @(negedge clk);
        busA.start = 1'b0;
        busA.mode  = ~md;
        busA.din   = {$urandom, $urandom};
        check("A_run_busy", 64'(busA.busy), 64'd1);
        lat = 0;
        while (!busA.done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("A_busy_at_done", 64'(busA.busy), 64'd0);
        res = busA.dout;
    endtask

    task automatic b_keyload(input logic [63:0] k);
        int cyc;
        busB.key      = k;
        busB.key_load = 1'b1;
        @(negedge clk);
        busB.key_load = 1'b0;
        cyc = 0;
        while (!busB.key_ready && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("B_exp_lat", 64'(cyc), 64'(TB - 1));
    endtask

    task automatic b_op(input logic md, input logic [31:0] d, output logic [63:0] res, output int lat);
        busB.mode  = md;
        busB.din   = d;
        busB.start = 1'b1;
        @(negedge clk);
        busB.start = 1'b0;
        busB.din   = $urandom;
        lat = 0;
        while (!busB.done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        res = 64'(busB.dout);
    endtask

    initial begin
        logic [127:0] ka, kr;
        logic [63:0]  res, expv, p1, p2, held;
        logic [63:0]  kb;
        logic         md;
        int           lat, cyc, seen;

        ka = 128'h1b1a1918_13121110_0b0a0908_03020100;
        kb = 64'h1918_1110_0908_0100;
        busA.key_load = 1'b0; busA.start = 1'b0; busA.mode = 1'b0;
        busA.key = '0; busA.din = '0;
        busB.key_load = 1'b0; busB.start = 1'b0; busB.mode = 1'b0;
        busB.key = '0; busB.din = '0;

        repeat (2) @(negedge clk);
        check("rst_key_ready", 64'(busA.key_ready), 64'd0);
        check("rst_busy", 64'(busA.busy), 64'd0);
        check("rst_done", 64'(busA.done), 64'd0);
        check("rst_dout", busA.dout, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        busA.din = 64'h3b726574_7475432d;
        busA.start = 1'b1;
        @(negedge clk);
        busA.start = 1'b0;
        check("nokey_busy", 64'(busA.busy), 64'd0);
        seen = 0;
        repeat (TA + 4) begin
            @(negedge clk);
            if (busA.done) seen++;
        end
        check("nokey_done", 64'(seen), 64'd0);
        check("nokey_dout", busA.dout, 64'd0);

        a_keyload(ka);
        a_op(1'b0, 64'h3b726574_7475432d, res, lat);
        check("enc_lat", 64'(lat), 64'(TA + 1));
        check("enc_vec", res, 64'h8c6fa548_454e028b);
        a_op(1'b1, 64'h8c6fa548_454e028b, res, lat);
        check("dec_lat", 64'(lat), 64'(TA + 1));
        check("dec_vec", res, 64'h3b726574_7475432d);

        // stray start and key_load during RUN
        p1 = {$urandom, $urandom};
        expv = speck_ref(ka, WA, MA, TA, AA, BA, 1'b0, p1);
        busA.mode = 1'b0; busA.din = p1; busA.start = 1'b1;
        @(negedge clk);
        busA.start = 1'b0;
        cyc = 0;
        repeat (5) begin
            @(negedge clk);
            cyc++;
        end
        busA.start = 1'b1; busA.mode = 1'b1; busA.din = ~p1;
        busA.key_load = 1'b1; busA.key = ~ka;
        @(negedge clk);
        cyc++;
        busA.start = 1'b0; busA.key_load = 1'b0;
        check("run_keyload_kr", 64'(busA.key_ready), 64'd1);
        while (!busA.done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("run_ignore_lat", 64'(cyc), 64'(TA + 1));
        check("run_ignore_res", busA.dout, expv);
        held = busA.dout;
        seen = 0;
        repeat (TA + 4) begin
            @(negedge clk);
            if (busA.done) seen++;
        end
        check("run_ignore_nodone", 64'(seen), 64'd0);
        check("run_ignore_hold", busA.dout, held);
        check("run_ignore_kr", 64'(busA.key_ready), 64'd1);
        p1 = {$urandom, $urandom};
        a_op(1'b0, p1, res, lat);
        check("oldkey_res", res, speck_ref(ka, WA, MA, TA, AA, BA, 1'b0, p1));

        // back-to-back start in the done cycle
        p1 = {$urandom, $urandom};
        p2 = {$urandom, $urandom};
        busA.mode = 1'b0; busA.din = p1; busA.start = 1'b1;
        @(negedge clk);
        busA.start = 1'b0;
        cyc = 0;
        while (!busA.done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("b2b_lat1", 64'(cyc), 64'(TA + 1));
        check("b2b_res1", busA.dout, speck_ref(ka, WA, MA, TA, AA, BA, 1'b0, p1));
        busA.mode = 1'b1; busA.din = p2; busA.start = 1'b1;
        @(negedge clk);
        busA.start = 1'b0;
        check("b2b_pulse", 64'(busA.done), 64'd0);
        cyc = 0;
        while (!busA.done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("b2b_lat2", 64'(cyc), 64'(TA + 1));
        check("b2b_res2", busA.dout, speck_ref(ka, WA, MA, TA, AA, BA, 1'b1, p2));

        for (int r = 0; r < 4; r++) begin
            kr = {$urandom, $urandom, $urandom, $urandom};
            a_keyload(refkey_a(kr));
            for (int q = 0; q < 2; q++) begin
                md = 1'($urandom_range(0, 1));
                p1 = {$urandom, $urandom};
                a_op(md, p1, res, lat);
                check("rnd_lat", 64'(lat), 64'(TA + 1));
                check("rnd_res", res, speck_ref(kr, WA, MA, TA, AA, BA, md, p1));
            end
        end

        b_keyload(kb);
        b_op(1'b0, 32'h6574_694c, res, lat);
        check("B_enc_lat", 64'(lat), 64'(TB + 1));
        check("B_enc_vec", res, 64'h0000_0000_a868_42f2);
        b_op(1'b1, 32'ha868_42f2, res, lat);
        check("B_dec_vec", res, 64'h0000_0000_6574_694c);
        for (int q = 0; q < 4; q++) begin
            md = 1'($urandom_range(0, 1));
            p1 = 64'($urandom);
            b_op(md, p1[31:0], res, lat);
            check("B_rnd_res", res, speck_ref(128'(kb), WB, MB, TB, AB, BB, md, p1));
        end

        // reset in the middle of RUN
        busA.mode = 1'b0; busA.din = {$urandom, $urandom}; busA.start = 1'b1;
        @(negedge clk);
        busA.start = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_rst_busy", 64'(busA.busy), 64'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", 64'(busA.busy), 64'd0);
        check("mid_rst_done", 64'(busA.done), 64'd0);
        check("mid_rst_kr", 64'(busA.key_ready), 64'd0);
        check("mid_rst_dout", busA.dout, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        busA.din = {$urandom, $urandom}; busA.start = 1'b1;
        @(negedge clk);
        busA.start = 1'b0;
        check("post_rst_busy", 64'(busA.busy), 64'd0);
        seen = 0;
        repeat (TA + 4) begin
            @(negedge clk);
            if (busA.done) seen++;
        end
        check("post_rst_nodone", 64'(seen), 64'd0);
        check("post_rst_dout", busA.dout, 64'd0);
        check("post_rst_kr", 64'(busA.key_ready), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/speck_block_cipher_param.md
Name: speck_block_cipher_param

Overview:
- Parametrised iterative SPECK encrypt/decrypt engine. It supersedes the fixed-width SPECK hash datapath/control pair, which had no decrypt mode.
- Performs on-chip key expansion into a round-key register file, then runs one round per clock in either direction under a start/done handshake.
- Sits between the host register interface and the hash/MAC wrapper; one instance per channel.

Parameters:
- WORD, 32, word width n in bits; block is 2*WORD.
- KEY_WORDS, 4, key words m (2..4).
- ROUNDS, 27, round count T.
- ALPHA, 8, right-rotate amount (7 when WORD=16).
- BETA, 3, left-rotate amount (2 when WORD=16).

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- key_load  input  1  pulse; samples key and starts expansion.
- key  input  WORD*KEY_WORDS  packed {l[m-2],...,l[0],k[0]}, k[0] in the LSBs.
- key_ready  output  1  round keys valid.
- start  input  1  pulse; samples din and mode.
- mode  input  1  0 = encrypt, 1 = decrypt.
- din  input  2*WORD  {x,y}, x in the upper word.
- busy  output  1  expansion or rounds in progress.
- done  output  1  one-cycle pulse; dout valid.
- dout  output  2*WORD  result {x,y}; holds until the next done.

Behaviour:
- Reset (async) values: state=IDLE, key_ready=0, busy=0, done=0, dout=0, round counter=0. Round-key file is not cleared; key_ready=0 makes it invalid.
- States: IDLE, EXPAND, RUN, FINISH.
- IDLE -> EXPAND on key_load.
  - Write rk[0]=k[0] and load the l registers; key_ready=0, busy=1.
- EXPAND: one step per cycle, i=0..ROUNDS-2.
  - l[i+m-1] = (rk[i] + ROR(l[i],ALPHA)) ^ i
  - rk[i+1] = ROL(rk[i],BETA) ^ l[i+m-1]
  - Addition is modulo 2^WORD; i is zero-extended to WORD.
  - After ROUNDS-1 cycles go to IDLE with key_ready=1, busy=0.
- IDLE -> RUN on start when key_ready=1.
  - Latch x,y from din and latch mode.
  - Counter = 0 for encrypt, ROUNDS-1 for decrypt.
- RUN: one round per cycle.
  - Encrypt with k=rk[cnt]: x' = (ROR(x,ALPHA)+y) ^ k; y' = ROL(y,BETA) ^ x'; cnt increments.
  - Decrypt with k=rk[cnt]: y' = ROR(x^y,BETA); x' = ROL((x^k) - y',ALPHA); cnt decrements. Subtraction is modulo 2^WORD.
  - After exactly ROUNDS rounds go to FINISH.
- FINISH: dout <= {x,y}, done=1 for one cycle, then IDLE; busy=0 in the same cycle as done.
- Latency: start sampled at edge E; rounds at edges E+1..E+ROUNDS; done high in the cycle after edge E+ROUNDS+1. Start-to-done is ROUNDS+1 cycles. Back-to-back start accepted in the cycle done is high: FINISH also accepts start.
- Boundary conditions:
  - start while key_ready=0 or busy=1: ignored. No state change; dout and done untouched.
  - key_load while busy (EXPAND or RUN): ignored. Current operation completes unchanged.
  - key_load and start in the same IDLE cycle: key_load wins; start is dropped.
  - key_load in IDLE while key_ready=1: key_ready drops the next cycle and re-expansion begins.
  - mode/din changes after start is sampled: no effect.
  - Counter limits: must not wrap. Encrypt stops at ROUNDS-1, decrypt at 0; both directions share one terminal-count compare.
  - reset mid-EXPAND or mid-RUN: immediate return to reset values; a subsequent start is rejected until a new key_load completes.

Test Plan:
- Encrypt, default params: key_load key=1b1a1918_13121110_0b0a0908_03020100; wait for key_ready (26 cycles); start mode=0 din=3b726574_7475432d -> done after 28 cycles, dout=8c6fa548_454e028b.
- Decrypt, same key: start mode=1 din=8c6fa548_454e028b -> dout=3b726574_7475432d.
- Reduced width: WORD=16, KEY_WORDS=4, ROUNDS=22, ALPHA=7, BETA=2; key=1918_1110_0908_0100, encrypt 6574_694c -> a868_42f2; decrypt round-trips back to 6574_694c.
- Protocol: start before key_ready, and start during RUN -> no done, dout unchanged. key_load during RUN -> ciphertext still matches the old key; key_ready stays 1.
- Back-to-back: start asserted in the done cycle -> second done exactly ROUNDS+1 cycles later with the correct result.
- Reset: assert reset at round 10 of RUN -> busy, done, key_ready and dout all 0 immediately; start before a new key_load is ignored.
